// File: rtl/sd_block_streamer.sv
// Multi-sector SPI-mode SD front end: moves N consecutive 512-byte sectors between sd_controller and a word stream.
// Optional feature macro: SD_STREAM_CHECKSUM_EN adds a 16-bit running byte sum on the checksum output.
module sd_block_streamer #(
   parameter int unsigned WORD_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned BYTE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [31:0]       cmd_lba,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic              err_unf,
   output logic [CNT_W-1:0]  sectors_done,
   output logic [15:0]       checksum,
   input  logic              sd_ready,
   input  logic              sd_byte_available,
   input  logic              sd_ready_for_next_byte,
   input  logic [7:0]        sd_dout,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic [31:0]       sd_addr,
   output logic [7:0]        sd_din
);

   localparam int unsigned NB     = WORD_W / 8;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam logic [1:0]  LAST_B = 2'(NB - 1);
   localparam logic [2:0]  NB_M1  = 3'(NB - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_XFER, S_DRAIN, S_DONE} state_t;
   state_t state_q, state_d;

   logic              write_q;
   logic [31:0]       lba_q;
   logic [CNT_W-1:0]  remain_q, secs_q;
   logic [8:0]        bytecnt_q;
   logic              ev_prev_q;
   logic [WORD_W-1:0] pack_q, pack_d, hold_q, hold_d, head, push_data;
   logic [1:0]        pack_idx_q, pack_idx_d;
   logic [2:0]        hold_cnt_q, hold_cnt_d;
   logic [7:0]        din_q, din_d;
   logic              ovf_q, unf_q, ovf_set, unf_set;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wp_q, rp_q;
   logic [AW:0]       cnt_q;
   logic              accept, ev_src, ev, last_ev, empty, full;
   logic              rd_push, rd_pop, wr_push, wr_pop, push, pop, ld;

   assign accept  = cmd_valid & (state_q == S_IDLE);
   assign ev_src  = write_q ? sd_ready_for_next_byte : sd_byte_available;
   assign ev      = (state_q == S_XFER) & ev_src & ~ev_prev_q;
   assign last_ev = ev & (bytecnt_q == 9'd511);
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign rd_pop  = ~write_q & ~empty & rd_ready;
   assign wr_push = wr_ready & wr_valid;
   assign push    = rd_push | wr_push;
   assign pop     = rd_pop | wr_pop;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = (cmd_count == '0) ? S_DONE : S_WAIT;
         S_WAIT:  if (sd_ready & (~write_q | ~empty)) state_d = S_ISSUE;
         S_ISSUE: if (~sd_ready) state_d = S_XFER;
         S_XFER:  if (last_ev) state_d = (remain_q == CNT_W'(1)) ? S_DRAIN : S_WAIT;
         S_DRAIN: if (write_q ? sd_ready : empty) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE) & (state_q != S_DONE);
      done      = (state_q == S_DONE);
      sd_rd     = (state_q == S_ISSUE) & ~write_q;
      sd_wr     = (state_q == S_ISSUE) & write_q;
      wr_ready  = (state_q != S_IDLE) & write_q & ~full;
   end

   // Write bytes come from a one-word holding register; an empty buffer with a
   // same-cycle push is served straight from wr_data so the count stays put.
   always_comb begin
      ld         = write_q & (((state_q == S_WAIT) & (state_d == S_ISSUE)) | (ev & ~last_ev));
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      din_d      = din_q;
      wr_pop     = 1'b0;
      unf_set    = 1'b0;
      head       = empty ? wr_data : mem[rp_q];
      if (ld) begin
         if (hold_cnt_q != '0) begin
            din_d      = hold_q[7:0];
            hold_d     = hold_q >> 8;
            hold_cnt_d = hold_cnt_q - 3'd1;
         end else if (~empty | wr_push) begin
            wr_pop     = 1'b1;
            din_d      = head[7:0];
            hold_d     = head >> 8;
            hold_cnt_d = NB_M1;
         end else begin
            din_d   = 8'hFF;
            unf_set = 1'b1;
         end
      end
      pack_d     = pack_q;
      pack_idx_d = pack_idx_q;
      rd_push    = 1'b0;
      ovf_set    = 1'b0;
      if (ev & ~write_q) begin
         for (int unsigned b = 0; b < NB; b++)
            if (pack_idx_q == 2'(b)) pack_d[8*b +: 8] = sd_dout;
         if (pack_idx_q == LAST_B) begin
            pack_idx_d = '0;
            if (~full | rd_pop) rd_push = 1'b1;
            else                ovf_set = 1'b1;
         end else begin
            pack_idx_d = pack_idx_q + 2'd1;
         end
      end
      push_data = write_q ? wr_data : pack_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q    <= 1'b0;
         lba_q      <= '0;
         remain_q   <= '0;
         secs_q     <= '0;
         bytecnt_q  <= '0;
         ev_prev_q  <= 1'b0;
         pack_q     <= '0;
         pack_idx_q <= '0;
         hold_q     <= '0;
         hold_cnt_q <= '0;
         din_q      <= 8'hFF;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
      end else begin
         ev_prev_q <= ev_src;
         if (accept) begin
            write_q    <= cmd_write;
            lba_q      <= cmd_lba;
            remain_q   <= cmd_count;
            secs_q     <= '0;
            bytecnt_q  <= '0;
            pack_idx_q <= '0;
            hold_cnt_q <= '0;
            din_q      <= 8'hFF;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
         end else begin
            if (ev) bytecnt_q <= bytecnt_q + 9'd1;
            if (last_ev) begin
               secs_q   <= secs_q + CNT_W'(1);
               lba_q    <= lba_q + 32'd1;
               remain_q <= remain_q - CNT_W'(1);
            end
            pack_q     <= pack_d;
            pack_idx_q <= pack_idx_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            din_q      <= din_d;
            ovf_q      <= ovf_q | ovf_set;
            unf_q      <= unf_q | unf_set;
         end
         if (push) wp_q <= wp_q + AW'(1);
         if (pop)  rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push & ~reset) mem[wp_q] <= push_data;
   end

`ifdef SD_STREAM_CHECKSUM_EN
   logic [15:0] csum_q;
   logic [7:0]  ev_byte;
   assign ev_byte = write_q ? din_q : sd_dout;
   always_ff @(posedge clk) begin
      if (reset | accept) csum_q <= '0;
      else if (ev)        csum_q <= csum_q + {8'h00, ev_byte};
   end
   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

   assign rd_valid     = ~write_q & ~empty;
   assign rd_data      = rd_valid ? mem[rp_q] : '0;
   assign err_ovf      = ovf_q;
   assign err_unf      = unf_q;
   assign sectors_done = secs_q;
   assign sd_din       = din_q;
   assign sd_addr      = (BYTE_ADDR != 0) ? {lba_q[22:0], 9'b0} : lba_q;

endmodule

// File: tb/tb_sd_block_streamer.sv
// Directed bench for sd_block_streamer with a behavioural SPI-mode sd_controller (one byte event per 16 clocks).
`timescale 1ns/1ps
module tb_sd_block_streamer;
   localparam int unsigned WW = 16;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, cmd_valid, cmd_ready, cmd_write;
   logic [31:0]   cmd_lba;
   logic [CW-1:0] cmd_count, sectors_done;
   logic [WW-1:0] rd_data, wr_data;
   logic          rd_valid, rd_ready, wr_valid, wr_ready;
   logic          busy, done, err_ovf, err_unf;
   logic [15:0]   checksum;
   logic          sd_ready, sd_byte_available, sd_ready_for_next_byte, sd_rd, sd_wr;
   logic [7:0]    sd_dout, sd_din;
   logic [31:0]   sd_addr;

   sd_block_streamer #(.WORD_W(WW), .FIFO_DEPTH(4), .CNT_W(CW), .BYTE_ADDR(1)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .busy(busy), .done(done), .err_ovf(err_ovf), .err_unf(err_unf),
      .sectors_done(sectors_done), .checksum(checksum),
      .sd_ready(sd_ready), .sd_byte_available(sd_byte_available),
      .sd_ready_for_next_byte(sd_ready_for_next_byte), .sd_dout(sd_dout),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr), .sd_din(sd_din)
   );

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] rbyte(input logic [31:0] lba, input int unsigned i, input logic one);
      return one ? 8'h01 : 8'(lba * 3 + i);
   endfunction

   function automatic logic [7:0] wbyte(input int unsigned i);
      return 8'(i * 5 + 1);
   endfunction

   function automatic logic [WW-1:0] exp_word(input logic [31:0] lba, input int unsigned n, input logic one);
      int unsigned b = 2 * n;
      logic [31:0] sec = lba + b / 512;
      return {rbyte(sec, b % 512 + 1, one), rbyte(sec, b % 512, one)};
   endfunction

   // Behavioural sd_controller
   logic          pat_one = 1'b0;
   int unsigned   ev_cnt = 0, ops_started = 0, ops_done = 0;
   logic [31:0]   addr_log[$];
   logic [7:0]    wr_cap[$];

   initial begin : sd_model
      logic [31:0] lba;
      logic        is_wr;
      sd_ready = 1'b1; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0; sd_dout = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (sd_rd || sd_wr) begin
            is_wr = sd_wr;
            addr_log.push_back(sd_addr);
            lba = sd_addr >> 9;
            sd_ready = 1'b0;
            ev_cnt = 0;
            ops_started++;
            for (int i = 0; i < 512; i++) begin
               repeat (15) @(posedge clk);
               #1;
               if (is_wr) begin
                  wr_cap.push_back(sd_din);
                  sd_ready_for_next_byte = 1'b1;
               end else begin
                  sd_dout = rbyte(lba, i, pat_one);
                  sd_byte_available = 1'b1;
               end
               ev_cnt++;
               @(posedge clk); #1;
               sd_byte_available = 1'b0;
               sd_ready_for_next_byte = 1'b0;
            end
            repeat (8) @(posedge clk);
            #1;
            sd_ready = 1'b1;
            ops_done++;
         end
      end
   end

   // Monitors
   int unsigned   done_cnt = 0, rdwr_cyc = 0, words_tot = 0, bad_tot = 0, mon_base = 0;
   logic [31:0]   mon_lba = '0;
   logic          busy_at_done = 1'b0, rdy_at_done = 1'b0;
   logic [WW-1:0] first_word = '0;

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         busy_at_done = busy;
         rdy_at_done = sd_ready;
      end
      if (sd_rd || sd_wr) rdwr_cyc++;
      if (rd_valid && rd_ready && !reset) begin
         if (words_tot == mon_base) first_word = rd_data;
         if (rd_data !== exp_word(mon_lba, words_tot - mon_base, pat_one)) bad_tot++;
         words_tot++;
      end
   end

   task automatic send_cmd(input logic wr, input logic [31:0] lba, input logic [CW-1:0] cnt);
      int unsigned n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_lba = lba; cmd_count = cnt;
      mon_lba = lba; mon_base = words_tot;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      check_eq("cmd_accept", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int unsigned budget);
      int unsigned start = done_cnt;
      int unsigned n = 0;
      while (done_cnt == start && n < budget) begin @(posedge clk); n++; end
      #1;
      check_eq(tag, done_cnt - start, 32'd1);
   endtask

   task automatic feed_words(input int unsigned nw);
      int unsigned n;
      for (int k = 0; k < nw; k++) begin
         wr_data = {wbyte(2 * k + 1), wbyte(2 * k)};
         wr_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!wr_ready && n < 20000) begin @(negedge clk); n++; end
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int unsigned ab, cb, b0, dc, rc, od, os, n, bad;
      logic [15:0] exp_sum;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lba = '0; cmd_count = '0;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_sd_din", {24'd0, sd_din}, 32'h0000_00FF);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check_eq("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
      check_eq("rst_sd_addr", sd_addr, 32'd0);
      reset = 1'b0;

      // Two-sector read, lba 5, byte addressing
      rd_ready = 1'b1; pat_one = 1'b0;
      ab = addr_log.size(); b0 = bad_tot;
      send_cmd(1'b0, 32'd5, 16'd2);
      wait_done("rdA_done", 40000);
      check_eq("rdA_words", words_tot - mon_base, 32'd512);
      check_eq("rdA_bad_words", bad_tot - b0, 32'd0);
      check_eq("rdA_first_word", {16'd0, first_word}, 32'h0000_100F);
      check_eq("rdA_n_issue", addr_log.size() - ab, 32'd2);
      if (addr_log.size() >= ab + 2) begin
         check_eq("rdA_addr0", addr_log[ab], 32'h0000_0A00);
         check_eq("rdA_addr1", addr_log[ab + 1], 32'h0000_0C00);
      end
      check_eq("rdA_sectors", {16'd0, sectors_done}, 32'd2);
      check_eq("rdA_busy_at_done", {31'd0, busy_at_done}, 32'd0);
      check_eq("rdA_err_ovf", {31'd0, err_ovf}, 32'd0);
`ifdef SD_STREAM_CHECKSUM_EN
      exp_sum = '0;
      for (int i = 0; i < 512; i++) exp_sum = exp_sum + {8'h00, rbyte(5, i, 1'b0)} + {8'h00, rbyte(6, i, 1'b0)};
      check_eq("rdA_checksum", {16'd0, checksum}, {16'd0, exp_sum});
`else
      check_eq("rdA_checksum", {16'd0, checksum}, 32'd0);
`endif

      // Single-sector write, lba 9, words streamed in
      ab = addr_log.size(); cb = wr_cap.size();
      fork
         feed_words(256);
      join_none
      send_cmd(1'b1, 32'd9, 16'd1);
      wait_done("wrB_done", 20000);
      check_eq("wrB_bytes", wr_cap.size() - cb, 32'd512);
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (cb + i < wr_cap.size() && wr_cap[cb + i] !== wbyte(i)) bad++;
      check_eq("wrB_bad_bytes", bad, 32'd0);
      if (wr_cap.size() >= cb + 2) begin
         check_eq("wrB_byte0", {24'd0, wr_cap[cb]}, 32'h01);
         check_eq("wrB_byte1", {24'd0, wr_cap[cb + 1]}, 32'h06);
      end
      if (addr_log.size() > ab) check_eq("wrB_addr", addr_log[ab], 32'h0000_1200);
      check_eq("wrB_err_unf", {31'd0, err_unf}, 32'd0);
      check_eq("wrB_sd_ready_at_done", {31'd0, rdy_at_done}, 32'd1);
      check_eq("wrB_sectors", {16'd0, sectors_done}, 32'd1);
`ifdef SD_STREAM_CHECKSUM_EN
      exp_sum = '0;
      for (int i = 0; i < 512; i++) exp_sum = exp_sum + {8'h00, wbyte(i)};
      check_eq("wrB_checksum", {16'd0, checksum}, {16'd0, exp_sum});
`endif

      // Read with stalled consumer: buffer fills, overflow flagged
      rd_ready = 1'b0; pat_one = 1'b1;
      od = ops_done; dc = done_cnt; b0 = bad_tot;
      send_cmd(1'b0, 32'd0, 16'd1);
      n = 0;
      while (ops_done == od && n < 12000) begin @(posedge clk); n++; end
      repeat (4) @(posedge clk);
      #1;
      check_eq("ovfC_events", ev_cnt, 32'd512);
      check_eq("ovfC_err_ovf", {31'd0, err_ovf}, 32'd1);
      check_eq("ovfC_rd_valid", {31'd0, rd_valid}, 32'd1);
      check_eq("ovfC_no_done_yet", done_cnt - dc, 32'd0);
      @(negedge clk);
      rd_ready = 1'b1;
      wait_done("ovfC_done", 100);
      check_eq("ovfC_words", words_tot - mon_base, 32'd4);
      check_eq("ovfC_bad_words", bad_tot - b0, 32'd0);
`ifdef SD_STREAM_CHECKSUM_EN
      check_eq("ovfC_checksum", {16'd0, checksum}, 32'h0000_0200);
`else
      check_eq("ovfC_checksum", {16'd0, checksum}, 32'd0);
`endif

      // Zero-count command
      dc = done_cnt; rc = rdwr_cyc;
      send_cmd(1'b0, 32'd7, 16'd0);
      check_eq("zeroD_done", {31'd0, done}, 32'd1);
      check_eq("zeroD_busy", {31'd0, busy}, 32'd0);
      check_eq("zeroD_err_cleared", {31'd0, err_ovf}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("zeroD_done_count", done_cnt - dc, 32'd1);
      check_eq("zeroD_no_sd_cmd", rdwr_cyc - rc, 32'd0);
      check_eq("zeroD_idle", {31'd0, cmd_ready}, 32'd1);

      // Reset in the middle of a read
      pat_one = 1'b0; rd_ready = 1'b1;
      os = ops_started; od = ops_done;
      send_cmd(1'b0, 32'd1, 16'd1);
      n = 0;
      while ((ops_started == os || ev_cnt < 100) && n < 4000) begin @(posedge clk); n++; end
      check_eq("rstE_reached_byte100", {31'd0, ev_cnt >= 100}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      dc = done_cnt;
      @(posedge clk); #1;
      check_eq("rstE_sd_rd", {31'd0, sd_rd}, 32'd0);
      check_eq("rstE_rd_valid", {31'd0, rd_valid}, 32'd0);
      check_eq("rstE_busy", {31'd0, busy}, 32'd0);
      check_eq("rstE_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rstE_sectors", {16'd0, sectors_done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (ops_done == od && n < 12000) begin @(posedge clk); n++; end
      repeat (4) @(posedge clk);
      #1;
      check_eq("rstE_no_done", done_cnt - dc, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
